pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
  clk  in  1  rising-edge clock
  rst  in  1  synchronous active-high reset
  ID_Rs  in  5  source register 1 of the instruction in ID
  ID_Rt  in  5  source register 2 of the instruction in ID
  EX_Rdst  in  5  destination register of the instruction in EX
  EX_MemR  in  1  instruction in EX is a load
  MEM_MemR  in  1  instruction in MEM is a load
  MEM_MemW  in  1  instruction in MEM is a store
  Mem_Ready  in  1  data memory completes the access this cycle
  Branch_Taken  in  1  EX resolved a taken branch or jump
  PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall, MEM_WB_Stall  out  1 each  hold the corresponding register
  IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush  out  1 each  bubble the corresponding pipeline register
  Mem_Timeout  out  1  sticky memory-wait timeout flag

Function
REQ-003 Stall and flush outputs SHALL be combinational functions of the inputs and the current state, so that they act in the same cycle; Mem_Timeout SHALL be registered.
REQ-004 mem_wait SHALL be defined as (MEM_MemR|MEM_MemW) & !Mem_Ready.
REQ-005 load_use SHALL be defined as EX_MemR & (EX_Rdst!=0) & (EX_Rdst==ID_Rs | EX_Rdst==ID_Rt).
REQ-006 Priority SHALL be mem_wait, then Branch_Taken, then load_use, then normal.
REQ-007 While mem_wait is set, PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall and MEM_WB_flush SHALL be 1, and all other outputs SHALL be 0.
REQ-008 During mem_wait, MEM_WB_Stall SHALL be 0, so that WB receives one bubble per wait cycle.
REQ-009 When Branch_Taken is set and mem_wait is clear, IF_ID_flush and ID_EX_flush SHALL be 1, all Stall outputs SHALL be 0, and load_use SHALL be ignored.
REQ-010 When load_use is set and neither mem_wait nor Branch_Taken is set, PC_Stall, IF_ID_Stall and ID_EX_flush SHALL be 1, and all other outputs SHALL be 0.
REQ-011 With no condition active, all Stall and flush outputs SHALL be 0.
REQ-012 The FSM SHALL have the states RUN and MWAIT: RUN goes to MWAIT when mem_wait=1; MWAIT stays in MWAIT while mem_wait=1; MWAIT goes to RUN when mem_wait=0.
REQ-013 An 8-bit wait counter SHALL be cleared on entry to MWAIT, SHALL increment each cycle spent in MWAIT, and SHALL saturate at 255.
REQ-014 Mem_Timeout SHALL be set on the clock edge where the counter is 254 and mem_wait is still 1, and SHALL remain set until rst.
REQ-015 A Branch_Taken or load_use condition present during MWAIT SHALL be acted on in the first cycle where mem_wait=0, because EX holds its state during the wait.
REQ-016 A mem_wait that starts in the same cycle as Branch_Taken SHALL suppress the flush; the flush SHALL then occur when the wait ends.

Reset
REQ-017 While rst=1, all Stall outputs SHALL be 0 and all flush outputs SHALL be 1, regardless of the other inputs.
REQ-018 On the clock edge with rst=1, the state SHALL become RUN, the wait counter SHALL become 0, Mem_Timeout SHALL become 0, and any performance counter SHALL become 0.
REQ-019 Reset asserted during MWAIT SHALL abandon the wait immediately, with no residual stall in the cycle after reset deasserts.

Configuration
REQ-020 The macro PIPE_CTRL_PERF_EN SHALL control a performance counter, as follows.
REQ-021 When PIPE_CTRL_PERF_EN is defined, the block SHALL add the output Stall_Cycles (out, 32 bits), which SHALL increment on every edge where PC_Stall=1, SHALL wrap from 0xFFFFFFFF to 0, and SHALL reset to 0.
REQ-022 When PIPE_CTRL_PERF_EN is not defined, the Stall_Cycles port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-023 Load-use: EX_MemR=1, EX_Rdst=5, ID_Rs=5 for one cycle -> PC_Stall=1, IF_ID_Stall=1, ID_EX_flush=1 that cycle; with EX_Rdst=0 -> all outputs 0.
REQ-024 Branch: Branch_Taken=1 together with a load_use match -> IF_ID_flush=1, ID_EX_flush=1, PC_Stall=0.
REQ-025 Memory wait: MEM_MemR=1 and Mem_Ready=0 for 3 cycles, then Mem_Ready=1 -> 3 cycles of 4 stalls plus MEM_WB_flush, MWAIT for 3 cycles, back to RUN, Mem_Timeout=0.
REQ-026 Timeout: MEM_MemW=1 and Mem_Ready=0 for 300 cycles -> Mem_Timeout rises after 255 MWAIT cycles, stays 1 after Mem_Ready=1, and clears only on rst.
REQ-027 Reset mid-wait: rst=1 during cycle 10 of a wait, then mem inputs idle -> during rst, stalls=0 and flushes=1; afterwards RUN, counter 0, outputs 0.
REQ-028 Performance counter (PIPE_CTRL_PERF_EN defined): 2-cycle load_use plus a 3-cycle mem_wait -> Stall_Cycles=5; preload 0xFFFFFFFF plus one stall -> Stall_Cycles=0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and pipe_ctrl (slave).
interface pipe_ctrl_if;
  localparam int unsigned REG_W = 5;

  logic [REG_W-1:0] ID_Rs;
  logic [REG_W-1:0] ID_Rt;
  logic [REG_W-1:0] EX_Rdst;
  logic             EX_MemR;
  logic             MEM_MemR;
  logic             MEM_MemW;
  logic             Mem_Ready;
  logic             Branch_Taken;

  logic PC_Stall;
  logic IF_ID_Stall;
  logic ID_EX_Stall;
  logic EX_MEM_Stall;
  logic MEM_WB_Stall;
  logic IF_ID_flush;
  logic ID_EX_flush;
  logic EX_MEM_flush;
  logic MEM_WB_flush;
  logic Mem_Timeout;

  modport master (
    output ID_Rs, ID_Rt, EX_Rdst, EX_MemR, MEM_MemR, MEM_MemW, Mem_Ready, Branch_Taken,
    input  PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall, MEM_WB_Stall,
    input  IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, Mem_Timeout
  );

  modport slave (
    input  ID_Rs, ID_Rt, EX_Rdst, EX_MemR, MEM_MemR, MEM_MemW, Mem_Ready, Branch_Taken,
    output PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall, MEM_WB_Stall,
    output IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, Mem_Timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait, branch and load-use stall/flush.
// Define PIPE_CTRL_PERF_EN to add the 32-bit Stall_Cycles performance counter.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] Stall_Cycles
`endif
);
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(255);
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(254);

  typedef enum logic [0:0] {RUN = 1'b0, MWAIT = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;
  logic             mem_wait;
  logic             load_use;

  assign mem_wait = (bus.MEM_MemR | bus.MEM_MemW) & ~bus.Mem_Ready;
  assign load_use = bus.EX_MemR & (bus.EX_Rdst != '0) &
                    ((bus.EX_Rdst == bus.ID_Rs) | (bus.EX_Rdst == bus.ID_Rt));

  // Same-cycle stall/flush decode; EX holds during a wait, so deferred
  // branch/load-use conditions are still on the inputs when the wait ends.
  always_comb begin
    bus.PC_Stall     = 1'b0;
    bus.IF_ID_Stall  = 1'b0;
    bus.ID_EX_Stall  = 1'b0;
    bus.EX_MEM_Stall = 1'b0;
    bus.MEM_WB_Stall = 1'b0;
    bus.IF_ID_flush  = 1'b0;
    bus.ID_EX_flush  = 1'b0;
    bus.EX_MEM_flush = 1'b0;
    bus.MEM_WB_flush = 1'b0;
    if (rst) begin
      bus.IF_ID_flush  = 1'b1;
      bus.ID_EX_flush  = 1'b1;
      bus.EX_MEM_flush = 1'b1;
      bus.MEM_WB_flush = 1'b1;
    end else if (mem_wait) begin
      bus.PC_Stall     = 1'b1;
      bus.IF_ID_Stall  = 1'b1;
      bus.ID_EX_Stall  = 1'b1;
      bus.EX_MEM_Stall = 1'b1;
      bus.MEM_WB_flush = 1'b1;
    end else if (bus.Branch_Taken) begin
      bus.IF_ID_flush  = 1'b1;
      bus.ID_EX_flush  = 1'b1;
    end else if (load_use) begin
      bus.PC_Stall     = 1'b1;
      bus.IF_ID_Stall  = 1'b1;
      bus.ID_EX_flush  = 1'b1;
    end
  end

  // Wait tracking FSM with saturating wait counter and sticky timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (state == RUN) begin
      wait_cnt <= '0;
      if (mem_wait) state <= MWAIT;
    end else if (mem_wait) begin
      if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CNT_W'(1);
      if (wait_cnt == CNT_TRIP) timeout_q <= 1'b1;
    end else begin
      state    <= RUN;
      wait_cnt <= '0;
    end
  end

  assign bus.Mem_Timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  // Counts every cycle the PC is held; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst)               Stall_Cycles <= '0;
    else if (bus.PC_Stall) Stall_Cycles <= Stall_Cycles + 32'(1);
  end
`endif
endmodule
